// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, bit-period timing, receiver state encoding
// and a small saturating-counter helper.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;
  localparam int unsigned CLK_FREQ_HZ = 50_000_000;
  localparam int unsigned BAUD_RATE   = 115_200;
  localparam int unsigned FULL_BIT    = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned HALF_BIT    = FULL_BIT / 2;

  typedef enum logic [1:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT
  } rx_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == 8'hFF) ? val : val + 8'd1;
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Two-port storage array: synchronous write, asynchronous read, no reset.
module fifo_mem_2p #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_o = mem_q[raddr_i];
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte queue behind the UART receiver, with occupancy,
// almost-full and sticky overflow reporting plus a saturating drop counter.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W      = UART_DATA_W,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned AFULL_LEVEL = 12,
  localparam int unsigned ADDR_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_reset_n,
  input  logic              i_wr_valid,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_clear,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_rd_ready,
  output logic [ADDR_W:0]   o_count,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_almost_full,
  output logic              o_overflow,
  output logic [7:0]        o_drop_count
);

  localparam logic [ADDR_W:0] AfullLevel = (ADDR_W + 1)'(AFULL_LEVEL);

  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;

  logic [ADDR_W:0] count;
  logic            empty, full, push, pop, drop, mem_we;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  always_comb begin
    count = wr_ptr_q - rd_ptr_q;
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
            (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    pop    = !empty && i_rd_ready;
    push   = i_wr_valid && (!full || pop);
    drop   = i_wr_valid && full && !pop;
    mem_we = push && !i_clear;
  end

  // Clear outranks push/pop; a byte arriving with clear is discarded silently.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (i_clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (drop) begin
        overflow_d = 1'b1;
        drop_cnt_d = sat_inc8(drop_cnt_q);
      end
    end
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  fifo_mem_2p #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i  (clk),
    .we_i   (mem_we),
    .waddr_i(wr_ptr_q[ADDR_W-1:0]),
    .wdata_i(i_wr_data),
    .raddr_i(rd_ptr_q[ADDR_W-1:0]),
    .rdata_o(o_rd_data)
  );

  always_comb begin
    o_rd_valid    = !empty;
    o_count       = count;
    o_empty       = empty;
    o_full        = full;
    o_almost_full = (count >= AfullLevel);
    o_overflow    = overflow_q;
    o_drop_count  = drop_cnt_q;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: directed scenarios followed by random traffic,
// with a queue-based reference model and an independent output monitor.
module tb_uart_rx_fifo;

  localparam int DEPTH  = 16;
  localparam int AFULL  = 12;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              i_reset_n = 1'b0;
  logic              i_wr_valid = 1'b0;
  logic [7:0]        i_wr_data = 8'h00;
  logic              i_clear = 1'b0;
  logic              i_rd_ready = 1'b0;
  logic              o_rd_valid;
  logic [7:0]        o_rd_data;
  logic [ADDR_W:0]   o_count;
  logic              o_empty;
  logic              o_full;
  logic              o_almost_full;
  logic              o_overflow;
  logic [7:0]        o_drop_count;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DATA_W     (8),
    .DEPTH      (DEPTH),
    .AFULL_LEVEL(AFULL)
  ) dut (
    .clk          (clk),
    .i_reset_n    (i_reset_n),
    .i_wr_valid   (i_wr_valid),
    .i_wr_data    (i_wr_data),
    .i_clear      (i_clear),
    .o_rd_valid   (o_rd_valid),
    .o_rd_data    (o_rd_data),
    .i_rd_ready   (i_rd_ready),
    .o_count      (o_count),
    .o_empty      (o_empty),
    .o_full       (o_full),
    .o_almost_full(o_almost_full),
    .o_overflow   (o_overflow),
    .o_drop_count (o_drop_count)
  );

  int         total = 0;
  int         bad = 0;
  logic [7:0] sb[$];
  int         mcount = 0;
  int         movf = 0;
  int         mdrop = 0;
  logic [7:0] last_rd = 8'h00;
  bit         m_pop, m_push;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input bit wv, input logic [7:0] wd, input bit rr, input bit clr);
    i_wr_valid = wv;
    i_wr_data  = wd;
    i_rd_ready = rr;
    i_clear    = clr;
    @(posedge clk);
    #1;
  endtask

  // Reference model: a count and an expected byte stream, stepped on each edge.
  initial forever begin
    @(posedge clk or negedge i_reset_n);
    if (!i_reset_n || i_clear) begin
      mcount = 0;
      sb.delete();
      movf  = 0;
      mdrop = 0;
    end else begin
      m_pop  = (mcount > 0) && i_rd_ready;
      m_push = i_wr_valid && ((mcount < DEPTH) || m_pop);
      if (m_pop) mcount--;
      if (m_push) begin
        mcount++;
        sb.push_back(i_wr_data);
      end else if (i_wr_valid) begin
        movf = 1;
        if (mdrop < 255) mdrop++;
      end
    end
  end

  // Monitor: compares flags every cycle and consumes the stream on each transfer.
  initial forever begin
    @(negedge clk);
    if (i_reset_n === 1'b1) begin
      chk("count", int'(o_count), mcount);
      chk("empty", int'(o_empty), int'(mcount == 0));
      chk("full", int'(o_full), int'(mcount == DEPTH));
      chk("almost_full", int'(o_almost_full), int'(mcount >= AFULL));
      chk("rd_valid", int'(o_rd_valid), int'(mcount != 0));
      chk("overflow", int'(o_overflow), movf);
      chk("drop_count", int'(o_drop_count), mdrop);
      if (o_rd_valid) begin
        if (sb.size() == 0) begin
          chk("stream_nonempty", 0, 1);
        end else begin
          chk("head_data", int'(o_rd_data), int'(sb[0]));
          if (i_rd_ready && !i_clear) last_rd = sb.pop_front();
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit wv, rr, cl;
    int ph;
    repeat (3) @(posedge clk);
    #1;
    i_reset_n = 1'b1;
    chk("rst_count", int'(o_count), 0);
    chk("rst_empty", int'(o_empty), 1);
    chk("rst_valid", int'(o_rd_valid), 0);
    chk("rst_ovf", int'(o_overflow), 0);

    // Basic ordering with a stalled consumer, then drain.
    cyc(1'b1, 8'h41, 1'b0, 1'b0);
    chk("fwft_valid", int'(o_rd_valid), 1);
    chk("fwft_data", int'(o_rd_data), 'h41);
    cyc(1'b1, 8'h42, 1'b0, 1'b0);
    cyc(1'b1, 8'h43, 1'b0, 1'b0);
    chk("three_count", int'(o_count), 3);
    repeat (3) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drain3_last", int'(last_rd), 'h43);
    chk("drain3_empty", int'(o_empty), 1);

    // Fill to full, then overflow twice.
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0);
      chk("fill_afull", int'(o_almost_full), int'((i + 1) >= AFULL));
    end
    chk("fill_full", int'(o_full), 1);
    cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    cyc(1'b1, 8'hBB, 1'b0, 1'b0);
    chk("ovf_flag", int'(o_overflow), 1);
    chk("ovf_drops", int'(o_drop_count), 2);
    chk("ovf_head", int'(o_rd_data), 'h00);

    // Push and pop together while full.
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    chk("fullpp_count", int'(o_count), DEPTH);
    chk("fullpp_drops", int'(o_drop_count), 2);
    chk("fullpp_head", int'(o_rd_data), 'h01);
    repeat (DEPTH) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fullpp_last", int'(last_rd), 'h55);
    chk("fullpp_empty", int'(o_empty), 1);

    // Alternating push/pop across pointer wrap.
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0);
      chk("alt_count_push", int'(o_count), 1);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("alt_count_pop", int'(o_count), 0);
    end
    chk("alt_last", int'(last_rd), 'h27);

    // Clear with a simultaneous push.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    chk("preclr_count", int'(o_count), 5);
    chk("preclr_ovf", int'(o_overflow), 1);
    cyc(1'b1, 8'h77, 1'b0, 1'b1);
    chk("clr_count", int'(o_count), 0);
    chk("clr_empty", int'(o_empty), 1);
    chk("clr_ovf", int'(o_overflow), 0);
    chk("clr_drops", int'(o_drop_count), 0);
    repeat (3) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("clr_novalid", int'(o_rd_valid), 0);
    end

    // Asynchronous reset between clock edges.
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'hD0 + i), 1'b0, 1'b0);
    #2;
    i_reset_n = 1'b0;
    #1;
    chk("arst_valid", int'(o_rd_valid), 0);
    chk("arst_count", int'(o_count), 0);
    i_wr_valid = 1'b0;
    @(posedge clk);
    #1;
    i_reset_n = 1'b1;
    cyc(1'b1, 8'h99, 1'b0, 1'b0);
    chk("arst_push_data", int'(o_rd_data), 'h99);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("arst_read_back", int'(last_rd), 'h99);

    // Random traffic alternating between drain-heavy and fill-heavy phases.
    for (int n = 0; n < 3000; n++) begin
      ph = n / 500;
      wv = ($urandom_range(99) < ((ph % 2) != 0 ? 80 : 40));
      rr = ($urandom_range(99) < ((ph % 2) != 0 ? 30 : 70));
      cl = ($urandom_range(299) == 0);
      cyc(wv, 8'($urandom), rr, cl);
    end
    repeat (DEPTH + 2) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("final_stream_left", sb.size(), 0);
    chk("final_empty", int'(o_empty), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
